// File: rtl/multiplexor_pkg.sv
// Shared constants for the multiplexor slice: select encodings and the widest
// supported data path.
package multiplexor_pkg;

   localparam logic MUX_SEL_IN0   = 1'b0;
   localparam logic MUX_SEL_IN1   = 1'b1;
   localparam int   MUX_MAX_WIDTH = 64;

endpackage

// File: rtl/multiplexor_if.sv
// Bundle of select, data, enable and result signals for the multiplexor.
// par_out exists only when MULTIPLEXOR_PARITY_EN is defined.
interface multiplexor_if #(
   parameter int WIDTH = 8
);

   logic             sel;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             en;
   logic [WIDTH-1:0] mux_out;
   logic [WIDTH-1:0] mux_out_q;
   logic             out_valid;
`ifdef MULTIPLEXOR_PARITY_EN
   logic             par_out;
`endif

`ifdef MULTIPLEXOR_PARITY_EN
   modport master (
      output sel, in0, in1, en,
      input  mux_out, mux_out_q, out_valid, par_out
   );
   modport slave (
      input  sel, in0, in1, en,
      output mux_out, mux_out_q, out_valid, par_out
   );
`else
   modport master (
      output sel, in0, in1, en,
      input  mux_out, mux_out_q, out_valid
   );
   modport slave (
      input  sel, in0, in1, en,
      output mux_out, mux_out_q, out_valid
   );
`endif

endinterface

// File: rtl/multiplexor_reg.sv
// Registered stage: enable-gated data flop, valid flop and, with
// MULTIPLEXOR_PARITY_EN, a parity flop loaded alongside the data.
module multiplexor_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
`ifdef MULTIPLEXOR_PARITY_EN
   output logic             par,
`endif
   output logic             valid
);

   // Data only moves on an enabled edge; valid simply follows en by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= '0;
         valid <= 1'b0;
      end else begin
         if (en) begin
            q <= d;
         end
         valid <= en;
      end
   end

`ifdef MULTIPLEXOR_PARITY_EN
   // Parity is computed from d so it lands in the same cycle as q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par <= 1'b0;
      end else if (en) begin
         par <= ^d;
      end
   end
`endif

endmodule

// File: rtl/multiplexor.sv
// Two-input WIDTH-bit multiplexor with a combinational output and an
// enable-captured registered copy; parity output under MULTIPLEXOR_PARITY_EN.
module multiplexor
   import multiplexor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   multiplexor_if.slave  bus
);

   // A ternary keeps X on differing bits when sel is unknown in simulation.
   assign bus.mux_out = (bus.sel == MUX_SEL_IN1) ? bus.in1 : bus.in0;

   multiplexor_reg #(
      .WIDTH (WIDTH)
   ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.en),
      .d     (bus.mux_out),
      .q     (bus.mux_out_q),
`ifdef MULTIPLEXOR_PARITY_EN
      .par   (bus.par_out),
`endif
      .valid (bus.out_valid)
   );

endmodule

// File: tb/tb_multiplexor.sv
// Directed self-checking bench for multiplexor at WIDTH=5; parity checks are
// included when MULTIPLEXOR_PARITY_EN is defined.
module tb_multiplexor;

   localparam int WIDTH = 5;

   logic clk = 1'b0;
   logic clk_run = 1'b1;
   logic rst_n;
   int   compared = 0;
   int   mismatched = 0;

   multiplexor_if #(.WIDTH(WIDTH)) dut_if ();

   multiplexor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dut_if)
   );

   // Gated clock so reset behaviour can be observed with no edges at all.
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      dut_if.sel = 1'b0;
      dut_if.in0 = '0;
      dut_if.in1 = '0;
      dut_if.en  = 1'b1;
      tick();
      tick();
      compared++;
      if (dut_if.mux_out_q !== 5'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_q got %h want %h", dut_if.mux_out_q, 5'h00);
      end
      compared++;
      if (dut_if.out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_valid got %b want %b", dut_if.out_valid, 1'b0);
      end
`ifdef MULTIPLEXOR_PARITY_EN
      compared++;
      if (dut_if.par_out !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_par got %b want %b", dut_if.par_out, 1'b0);
      end
`endif
      // Clock stopped, still in reset: combinational path must stay live.
      clk_run = 1'b0;
      #3;
      dut_if.sel = 1'b1;
      dut_if.in1 = 5'h1F;
      #1;
      compared++;
      if (dut_if.mux_out !== 5'h1F) begin
         mismatched++;
         $display("[TB] FAIL reset_comb got %h want %h", dut_if.mux_out, 5'h1F);
      end
      compared++;
      if (dut_if.mux_out_q !== 5'h00 || dut_if.out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_stopped got q=%h v=%b want q=00 v=0",
                  dut_if.mux_out_q, dut_if.out_valid);
      end
   endtask

   task automatic test_comb_select();
      dut_if.sel = 1'b0; dut_if.in0 = 5'h15; dut_if.in1 = 5'h00;
      #1;
      compared++;
      if (dut_if.mux_out !== 5'h15) begin
         mismatched++;
         $display("[TB] FAIL comb_a got %h want %h", dut_if.mux_out, 5'h15);
      end
      dut_if.in0 = 5'h0A;
      #1;
      compared++;
      if (dut_if.mux_out !== 5'h0A) begin
         mismatched++;
         $display("[TB] FAIL comb_b got %h want %h", dut_if.mux_out, 5'h0A);
      end
      dut_if.sel = 1'b1; dut_if.in0 = 5'h00; dut_if.in1 = 5'h15;
      #1;
      compared++;
      if (dut_if.mux_out !== 5'h15) begin
         mismatched++;
         $display("[TB] FAIL comb_c got %h want %h", dut_if.mux_out, 5'h15);
      end
      dut_if.in1 = 5'h0A;
      #1;
      compared++;
      if (dut_if.mux_out !== 5'h0A) begin
         mismatched++;
         $display("[TB] FAIL comb_d got %h want %h", dut_if.mux_out, 5'h0A);
      end
      dut_if.sel = 1'b0; dut_if.in0 = 5'h13;
      #1;
      compared++;
      if (dut_if.mux_out !== 5'h13) begin
         mismatched++;
         $display("[TB] FAIL comb_e got %h want %h", dut_if.mux_out, 5'h13);
      end
   endtask

   task automatic test_capture_hold();
      dut_if.en = 1'b0;
      rst_n = 1'b1;
      clk_run = 1'b1;
      tick();
      compared++;
      if (dut_if.mux_out_q !== 5'h00 || dut_if.out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL no_capture_en0 got q=%h v=%b want q=00 v=0",
                  dut_if.mux_out_q, dut_if.out_valid);
      end
      dut_if.sel = 1'b0; dut_if.in0 = 5'h15; dut_if.en = 1'b1;
      tick();
      compared++;
      if (dut_if.mux_out_q !== 5'h15 || dut_if.out_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL capture got q=%h v=%b want q=15 v=1",
                  dut_if.mux_out_q, dut_if.out_valid);
      end
`ifdef MULTIPLEXOR_PARITY_EN
      compared++;
      if (dut_if.par_out !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL par_15 got %b want %b", dut_if.par_out, 1'b1);
      end
`endif
      dut_if.en = 1'b0; dut_if.in0 = 5'h03;
      tick();
      compared++;
      if (dut_if.mux_out_q !== 5'h15 || dut_if.out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL hold got q=%h v=%b want q=15 v=0",
                  dut_if.mux_out_q, dut_if.out_valid);
      end
      compared++;
      if (dut_if.mux_out !== 5'h03) begin
         mismatched++;
         $display("[TB] FAIL hold_comb got %h want %h", dut_if.mux_out, 5'h03);
      end
   endtask

   task automatic test_back_to_back();
      logic       sels [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [4:0] d0s  [4] = '{5'h11, 5'h02, 5'h07, 5'h0A};
      logic [4:0] d1s  [4] = '{5'h01, 5'h1C, 5'h1F, 5'h05};
      logic [4:0] exps [4] = '{5'h01, 5'h02, 5'h1F, 5'h0A};
      for (int i = 0; i < 4; i++) begin
         dut_if.sel = sels[i]; dut_if.in0 = d0s[i]; dut_if.in1 = d1s[i];
         dut_if.en = 1'b1;
         tick();
         compared++;
         if (dut_if.mux_out_q !== exps[i] || dut_if.out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_%0d got q=%h v=%b want q=%h v=1",
                     i, dut_if.mux_out_q, dut_if.out_valid, exps[i]);
         end
      end
`ifdef MULTIPLEXOR_PARITY_EN
      compared++;
      if (dut_if.par_out !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL par_0a got %b want %b", dut_if.par_out, 1'b0);
      end
`endif
      dut_if.en = 1'b0;
      tick();
      compared++;
      if (dut_if.out_valid !== 1'b0 || dut_if.mux_out_q !== 5'h0A) begin
         mismatched++;
         $display("[TB] FAIL b2b_end got q=%h v=%b want q=0a v=0",
                  dut_if.mux_out_q, dut_if.out_valid);
      end
   endtask

   task automatic test_async_reset();
      dut_if.sel = 1'b0; dut_if.in0 = 5'h15; dut_if.en = 1'b1;
      tick();
      // Pulse reset between edges: flops must clear with no clock edge.
      #1;
      rst_n = 1'b0;
      #1;
      compared++;
      if (dut_if.mux_out_q !== 5'h00 || dut_if.out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL async_rst got q=%h v=%b want q=00 v=0",
                  dut_if.mux_out_q, dut_if.out_valid);
      end
`ifdef MULTIPLEXOR_PARITY_EN
      compared++;
      if (dut_if.par_out !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL async_rst_par got %b want %b", dut_if.par_out, 1'b0);
      end
`endif
      dut_if.in0 = 5'h0B;
      tick();
      compared++;
      if (dut_if.mux_out_q !== 5'h00 || dut_if.out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rst_discard got q=%h v=%b want q=00 v=0",
                  dut_if.mux_out_q, dut_if.out_valid);
      end
      #3;
      rst_n = 1'b1;
      tick();
      compared++;
      if (dut_if.mux_out_q !== 5'h0B || dut_if.out_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL first_after_rst got q=%h v=%b want q=0b v=1",
                  dut_if.mux_out_q, dut_if.out_valid);
      end
      dut_if.en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_comb_select();
      test_capture_hold();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/multiplexor.md
MULTIPLEXOR -- requirements
Module: multiplexor

Interface
REQ-001 Parameter WIDTH, default 8, sets the data width in bits; legal values are 1..64.
REQ-002 clk  input  1  rising-edge clock for the registered stage; the single clock of the block.
REQ-003 rst_n  input  1  asynchronous, active-low reset for all flops.
REQ-004 sel  input  1  source select; 0 selects in0, 1 selects in1.
REQ-005 in0  input  WIDTH  data source 0.
REQ-006 in1  input  WIDTH  data source 1.
REQ-007 en  input  1  capture enable for the registered stage.
REQ-008 mux_out  output  WIDTH  combinational selected data.
REQ-009 mux_out_q  output  WIDTH  registered selected data.
REQ-010 out_valid  output  1  high for the cycle after a capture.
REQ-011 par_out  output  1  even parity of mux_out_q; present only when MULTIPLEXOR_PARITY_EN is defined.

Function
REQ-012 mux_out SHALL equal in0 when sel=0 and in1 when sel=1, purely combinationally, with zero clock latency.
REQ-013 mux_out SHALL be independent of clk, rst_n and en, and SHALL stay valid while in reset.
REQ-014 When sel is X/Z in simulation, mux_out SHALL be X on bits where in0 and in1 differ.
REQ-015 On each rising clk edge with en=1, mux_out_q SHALL load the current mux_out value (one-cycle latency).
REQ-016 With en=0, mux_out_q SHALL hold its value.
REQ-017 out_valid SHALL register en, so it is high exactly in the cycle after each capture edge.
REQ-018 Back-to-back en=1 cycles SHALL capture every cycle, and out_valid SHALL stay high continuously.
REQ-019 A sel or data change coincident with a capture edge SHALL capture the pre-edge mux_out value.
REQ-020 Width rule: there is no truncation or extension; all data paths are exactly WIDTH bits.

Reset
REQ-021 Asserting rst_n=0 SHALL immediately clear mux_out_q to 0 and out_valid to 0, independent of clk.
REQ-022 Deassertion SHALL be synchronous to clk.
REQ-023 The first capture SHALL occur on the first rising edge with rst_n=1 and en=1.
REQ-024 Reset asserted mid-stream SHALL discard the pending capture.
REQ-025 par_out SHALL read 0 during reset, when MULTIPLEXOR_PARITY_EN is defined.

Configuration
REQ-026 Macro MULTIPLEXOR_PARITY_EN defined: par_out SHALL exist and equal the XOR-reduction of mux_out_q, registered in the same cycle as mux_out_q.
REQ-027 Macro MULTIPLEXOR_PARITY_EN undefined: there SHALL be no par_out port and no parity logic, and all other behaviour is unchanged.

Structure
REQ-028 The shared package multiplexor_pkg SHALL hold the constants MUX_SEL_IN0=1'b0, MUX_SEL_IN1=1'b1 and MUX_MAX_WIDTH=64.
REQ-029 The registered stage SHALL be the sub-module multiplexor_reg, which contains the WIDTH-bit enable flop, the valid flop and the optional parity flop.
REQ-030 The top level SHALL contain only the combinational select plus the multiplexor_reg instance.

Verification (WIDTH=5)
REQ-031 sel=0, in0=0x15, in1=0x00 -> mux_out=0x15 within 1 time unit, with no clock edge.
REQ-032 sel=0, in0=0x0A, in1=0x00 -> mux_out=0x0A; then sel=1, in0=0x00, in1=0x15 -> mux_out=0x15; then in1=0x0A -> mux_out=0x0A.
REQ-033 rst_n=0 with clk stopped and inputs sel=1, in1=0x1F -> mux_out=0x1F, mux_out_q=0, out_valid=0.
REQ-034 Capture/hold sequence -> mux_out_q=0x15 and out_valid=1 the cycle after en=1 captures sel=0, in0=0x15; en=0 with in0 changed to 0x03 -> mux_out_q holds 0x15 and out_valid=0.
REQ-035 Reset and parity sequence -> after mux_out_q=0x15, rst_n pulses low between edges -> mux_out_q=0 asynchronously; with MULTIPLEXOR_PARITY_EN, capturing 0x15 -> par_out=1 and capturing 0x0A -> par_out=0.
